// File: rtl/bram_port_arbiter.sv
// Single-port BRAM arbiter: fixed-priority core (index 0), round-robin for the rest,
// fixed-latency read-response routing and a zero-fill clear sequencer. Optional stall statistic via BRAM_ARB_STATS_EN.
module bram_port_arbiter #(
    parameter int pDATA_WIDTH = 32,
    parameter int pADDR_WIDTH = 10,
    parameter int NUM_REQ     = 3,
    parameter int pDEPTH      = 1024,
    parameter int RD_LAT      = 1,
    parameter int LITE_IDX    = 2
) (
    input  logic                           axis_clk,
    input  logic                           axis_rst,
    input  logic                           in_ap_idle,
    input  logic [NUM_REQ-1:0]             in_req_valid,
    input  logic [NUM_REQ-1:0]             in_req_we,
    input  logic [NUM_REQ*pADDR_WIDTH-1:0] in_req_addr,
    input  logic [NUM_REQ*pDATA_WIDTH-1:0] in_req_wdata,
    output logic [NUM_REQ-1:0]             out_req_ready,
    output logic [NUM_REQ-1:0]             out_rsp_valid,
    output logic [pDATA_WIDTH-1:0]         out_rsp_data,
    input  logic                           in_clr_start,
    output logic                           out_clr_busy,
    output logic                           out_clr_done,
    output logic                           out_ram_EN,
    output logic [pDATA_WIDTH/8-1:0]       out_ram_WE,
    output logic [pADDR_WIDTH-1:0]         out_ram_A,
    output logic [pDATA_WIDTH-1:0]         out_ram_Di,
    input  logic [pDATA_WIDTH-1:0]         in_ram_Do,
    output logic [15:0]                    out_stall_cnt
);

    localparam int BE_W  = pDATA_WIDTH / 8;
    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [pADDR_WIDTH-1:0] LAST_ADDR = pADDR_WIDTH'(pDEPTH - 1);
    localparam logic [PTR_W-1:0]       PTR_FIRST = PTR_W'(1);

    typedef enum logic {
        ST_ARB = 1'b0,
        ST_CLR = 1'b1
    } state_e;

    state_e                   state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [pADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [NUM_REQ-1:0]       elig_s;
    logic [NUM_REQ-1:0]       grant_s;
    logic                     found_s;
    logic                     hit_s;
    logic                     sel_we_s;
    logic [pADDR_WIDTH-1:0]   sel_addr_s;
    logic [pDATA_WIDTH-1:0]   sel_wdata_s;
    logic                     ram_en_q;
    logic [BE_W-1:0]          ram_we_q;
    logic [pADDR_WIDTH-1:0]   ram_a_q;
    logic [pDATA_WIDTH-1:0]   ram_di_q;
    logic [NUM_REQ-1:0]       rsp_pipe_q [0:RD_LAT];
    logic                     clr_busy_q;
    logic                     clr_done_q;

    // Distance of requester idx from the round-robin pointer, wrapping over 1..NUM_REQ-1.
    function automatic int rr_dist(input int idx, input logic [PTR_W-1:0] ptr);
        if (idx >= int'(ptr)) begin
            return idx - int'(ptr);
        end else begin
            return idx - int'(ptr) + NUM_REQ - 1;
        end
    endfunction

    // FSM state, round-robin pointer and clear address counter
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state_q   <= ST_ARB;
            rr_ptr_q  <= PTR_FIRST;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic: a clear runs exactly pDEPTH cycles then returns to arbitration
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_ARB: begin
                clr_cnt_d = '0;
                if (in_clr_start) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_ARB;
                end
            end
            ST_CLR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_ARB;
                    clr_cnt_d = '0;
                end else begin
                    state_d   = ST_CLR;
                    clr_cnt_d = clr_cnt_q + pADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d   = ST_ARB;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Grant selection; the clear-start cycle issues no grant
    always_comb begin
        grant_s  = '0;
        rr_ptr_d = rr_ptr_q;
        found_s  = 1'b0;
        hit_s    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig_s[i] = in_req_valid[i] && ((i != LITE_IDX) || in_ap_idle);
        end
        if ((state_q == ST_ARB) && !in_clr_start) begin
            if (elig_s[0]) begin
                grant_s[0] = 1'b1;
            end else begin
                for (int d = 0; d < NUM_REQ - 1; d++) begin
                    for (int i = 1; i < NUM_REQ; i++) begin
                        hit_s      = !found_s && elig_s[i] && (rr_dist(i, rr_ptr_q) == d);
                        grant_s[i] = grant_s[i] | hit_s;
                        found_s    = found_s | hit_s;
                        if (hit_s) begin
                            rr_ptr_d = (i == NUM_REQ - 1) ? PTR_FIRST : PTR_W'(i + 1);
                        end else begin
                            rr_ptr_d = rr_ptr_d;
                        end
                    end
                end
            end
        end else begin
            grant_s = '0;
        end
    end

    // One-hot AND-OR mux of the granted requester's command
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we_s    = sel_we_s | (grant_s[i] & in_req_we[i]);
            sel_addr_s  = sel_addr_s  | ({pADDR_WIDTH{grant_s[i]}} & in_req_addr[i*pADDR_WIDTH +: pADDR_WIDTH]);
            sel_wdata_s = sel_wdata_s | ({pDATA_WIDTH{grant_s[i]}} & in_req_wdata[i*pDATA_WIDTH +: pDATA_WIDTH]);
        end
    end

    // Registered BRAM port drive
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            ram_en_q <= 1'b0;
            ram_we_q <= '0;
            ram_a_q  <= '0;
            ram_di_q <= '0;
        end else if (state_q == ST_CLR) begin
            ram_en_q <= 1'b1;
            ram_we_q <= {BE_W{1'b1}};
            ram_a_q  <= clr_cnt_q;
            ram_di_q <= '0;
        end else if (|grant_s) begin
            ram_en_q <= 1'b1;
            ram_we_q <= sel_we_s ? {BE_W{1'b1}} : {BE_W{1'b0}};
            ram_a_q  <= sel_addr_s;
            ram_di_q <= sel_wdata_s;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= '0;
        end
    end

    // Read-response pipe: stage k holds the one-hot owner of a read issued k+1 cycles ago
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            for (int k = 0; k <= RD_LAT; k++) begin
                rsp_pipe_q[k] <= '0;
            end
        end else begin
            rsp_pipe_q[0] <= grant_s & ~in_req_we;
            for (int k = 1; k <= RD_LAT; k++) begin
                rsp_pipe_q[k] <= rsp_pipe_q[k-1];
            end
        end
    end

    // Clear status flags, aligned with the clear writes on the BRAM port
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            clr_busy_q <= (state_q == ST_CLR);
            clr_done_q <= clr_busy_q && (ram_a_q == LAST_ADDR);
        end
    end

`ifdef BRAM_ARB_STATS_EN
    logic        stall_s;
    logic [15:0] stall_cnt_q;

    assign stall_s = |(in_req_valid & ~grant_s);

    // Saturating count of cycles in which some valid requester is left waiting
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            stall_cnt_q <= 16'h0000;
        end else if (stall_s && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_q <= stall_cnt_q;
        end
    end

    assign out_stall_cnt = stall_cnt_q;
`else
    assign out_stall_cnt = 16'h0000;
`endif

    assign out_req_ready = grant_s;
    assign out_rsp_valid = rsp_pipe_q[RD_LAT];
    assign out_rsp_data  = (|rsp_pipe_q[RD_LAT]) ? in_ram_Do : {pDATA_WIDTH{1'b0}};
    assign out_clr_busy  = clr_busy_q;
    assign out_clr_done  = clr_done_q;
    assign out_ram_EN    = ram_en_q;
    assign out_ram_WE    = ram_we_q;
    assign out_ram_A     = ram_a_q;
    assign out_ram_Di    = ram_di_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter (pDEPTH = 8): table-driven grant vectors, BRAM model,
// read-response scoreboard and hand-written clear / reset sequences.
module tb_bram_port_arbiter;

    logic         axis_clk;
    logic         axis_rst;
    logic         in_ap_idle;
    logic [2:0]   in_req_valid;
    logic [2:0]   in_req_we;
    logic [29:0]  in_req_addr;
    logic [95:0]  in_req_wdata;
    logic [2:0]   out_req_ready;
    logic [2:0]   out_rsp_valid;
    logic [31:0]  out_rsp_data;
    logic         in_clr_start;
    logic         out_clr_busy;
    logic         out_clr_done;
    logic         out_ram_EN;
    logic [3:0]   out_ram_WE;
    logic [9:0]   out_ram_A;
    logic [31:0]  out_ram_Di;
    logic [31:0]  in_ram_Do;
    logic [15:0]  out_stall_cnt;

    bram_port_arbiter #(.pDEPTH(8)) dut (
        .axis_clk(axis_clk), .axis_rst(axis_rst), .in_ap_idle(in_ap_idle),
        .in_req_valid(in_req_valid), .in_req_we(in_req_we), .in_req_addr(in_req_addr),
        .in_req_wdata(in_req_wdata), .out_req_ready(out_req_ready), .out_rsp_valid(out_rsp_valid),
        .out_rsp_data(out_rsp_data), .in_clr_start(in_clr_start), .out_clr_busy(out_clr_busy),
        .out_clr_done(out_clr_done), .out_ram_EN(out_ram_EN), .out_ram_WE(out_ram_WE),
        .out_ram_A(out_ram_A), .out_ram_Di(out_ram_Di), .in_ram_Do(in_ram_Do),
        .out_stall_cnt(out_stall_cnt)
    );

    typedef struct {
        logic        idle;
        logic [2:0]  valid;
        logic [2:0]  we;
        logic [9:0]  addr;   // requester i uses addr + i
        logic [31:0] wdata;  // requester i uses wdata + i
        logic [2:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] data;
        int          due;
    } rsp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    rsp_t        sb[$];
    logic [31:0] ram    [1024];
    logic [31:0] shadow [1024];
    vec_t        vecs   [20];
    logic [15:0] stall0;
    int          wait_n;

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;
    always @(posedge axis_clk) cyc <= cyc + 1;

    // Single-port BRAM, RD_LAT = 1, byte write enables
    always @(posedge axis_clk) begin
        if (out_ram_EN) begin
            if (out_ram_WE != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (out_ram_WE[b]) ram[out_ram_A][8*b +: 8] <= out_ram_Di[8*b +: 8];
                end
            end else begin
                in_ram_Do <= ram[out_ram_A];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Response monitor: compare against the scoreboard head when it falls due
    always @(negedge axis_clk) begin
        if (!axis_rst) begin
            if ((sb.size() > 0) && (sb[0].due == cyc)) begin
                chk("rsp_valid", {29'd0, out_rsp_valid}, {29'd0, sb[0].id});
                chk("rsp_data", out_rsp_data, sb[0].data);
                void'(sb.pop_front());
            end else if (out_rsp_valid != 3'b000) begin
                chk("rsp_spurious", {29'd0, out_rsp_valid}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic idle, input logic [2:0] v, input logic [2:0] w,
                                input logic [9:0] a, input logic [31:0] d, input logic [2:0] e);
        vec_t r;
        r.idle = idle; r.valid = v; r.we = w; r.addr = a; r.wdata = d; r.exp_ready = e;
        return r;
    endfunction

    task automatic set_in(input logic idle, input logic [2:0] v, input logic [2:0] w,
                          input logic [9:0] a, input logic [31:0] d);
        in_ap_idle   = idle;
        in_req_valid = v;
        in_req_we    = w;
        in_req_addr  = {a + 10'd2, a + 10'd1, a};
        in_req_wdata = {d + 32'd2, d + 32'd1, d};
    endtask

    // Check ready in the current cycle, update the shadow memory / scoreboard, advance one cycle
    task automatic step(input string nm, input logic [2:0] exp_rdy, input bit track);
        rsp_t r;
        logic [9:0] a;
        @(negedge axis_clk);
        chk(nm, {29'd0, out_req_ready}, {29'd0, exp_rdy});
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i] && track) begin
                a = in_req_addr[i*10 +: 10];
                if (in_req_we[i]) begin
                    shadow[a] = in_req_wdata[i*32 +: 32];
                end else begin
                    r.id   = 3'b001 << i;
                    r.data = shadow[a];
                    r.due  = cyc + 2;
                    sb.push_back(r);
                end
            end
        end
        @(posedge axis_clk);
        #1;
    endtask

    initial begin
        vecs[0]  = mk(1'b1, 3'b111, 3'b111, 10'd16, 32'hA000_0000, 3'b001);
        vecs[1]  = mk(1'b1, 3'b111, 3'b111, 10'd20, 32'hA000_0010, 3'b001);
        vecs[2]  = mk(1'b1, 3'b111, 3'b111, 10'd24, 32'hA000_0020, 3'b001);
        vecs[3]  = mk(1'b1, 3'b110, 3'b110, 10'd28, 32'hB000_0000, 3'b010);
        vecs[4]  = mk(1'b1, 3'b110, 3'b110, 10'd32, 32'hB000_0010, 3'b100);
        vecs[5]  = mk(1'b1, 3'b110, 3'b110, 10'd36, 32'hB000_0020, 3'b010);
        vecs[6]  = mk(1'b1, 3'b110, 3'b110, 10'd40, 32'hB000_0030, 3'b100);
        vecs[7]  = mk(1'b0, 3'b100, 3'b100, 10'd44, 32'hC000_0000, 3'b000);
        vecs[8]  = mk(1'b1, 3'b100, 3'b100, 10'd44, 32'hC000_0000, 3'b100);
        vecs[9]  = mk(1'b0, 3'b110, 3'b110, 10'd48, 32'hC000_0010, 3'b010);
        vecs[10] = mk(1'b0, 3'b110, 3'b110, 10'd52, 32'hC000_0020, 3'b010);
        vecs[11] = mk(1'b1, 3'b010, 3'b010, 10'd4,  32'hDEAD_BEEE, 3'b010);
        vecs[12] = mk(1'b1, 3'b100, 3'b000, 10'd3,  32'h0,         3'b100);
        vecs[13] = mk(1'b1, 3'b111, 3'b000, 10'd16, 32'h0,         3'b001);
        vecs[14] = mk(1'b1, 3'b110, 3'b000, 10'd28, 32'h0,         3'b010);
        vecs[15] = mk(1'b1, 3'b110, 3'b000, 10'd32, 32'h0,         3'b100);
        vecs[16] = mk(1'b1, 3'b010, 3'b000, 10'd52, 32'h0,         3'b010);
        vecs[17] = mk(1'b1, 3'b001, 3'b001, 10'd3,  32'h3333_0000, 3'b001);
        vecs[18] = mk(1'b1, 3'b000, 3'b000, 10'd0,  32'h0,         3'b000);
        vecs[19] = mk(1'b1, 3'b000, 3'b000, 10'd0,  32'h0,         3'b000);

        axis_rst = 1'b1;
        in_clr_start = 1'b0;
        set_in(1'b0, 3'b000, 3'b000, 10'd0, 32'h0);
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        chk("rst_ready", {29'd0, out_req_ready}, 32'd0);
        chk("rst_rsp_valid", {29'd0, out_rsp_valid}, 32'd0);
        chk("rst_rsp_data", out_rsp_data, 32'd0);
        chk("rst_busy", {31'd0, out_clr_busy}, 32'd0);
        chk("rst_done", {31'd0, out_clr_done}, 32'd0);
        chk("rst_en", {31'd0, out_ram_EN}, 32'd0);
        chk("rst_we", {28'd0, out_ram_WE}, 32'd0);
        chk("rst_addr", {22'd0, out_ram_A}, 32'd0);
        chk("rst_di", out_ram_Di, 32'd0);
        chk("rst_stall", {16'd0, out_stall_cnt}, 32'd0);
        @(posedge axis_clk);
        #1;
        axis_rst = 1'b0;

        for (int v = 0; v < 20; v++) begin
            set_in(vecs[v].idle, vecs[v].valid, vecs[v].we, vecs[v].addr, vecs[v].wdata);
            step($sformatf("vec%0d_ready", v), vecs[v].exp_ready, 1'b1);
        end

        // Full clear with a read in flight and no grant in the start cycle
        set_in(1'b1, 3'b001, 3'b000, 10'd3, 32'h0);
        step("pre_clr_read", 3'b001, 1'b1);
        in_clr_start = 1'b1;
        set_in(1'b1, 3'b011, 3'b000, 10'd3, 32'h0);
        step("clr_start_no_grant", 3'b000, 1'b1);
        in_clr_start = 1'b0;
        set_in(1'b1, 3'b000, 3'b000, 10'd0, 32'h0);
        wait_n = 0;
        @(negedge axis_clk);
        while (!out_clr_busy && (wait_n < 4)) begin
            @(posedge axis_clk); #1; @(negedge axis_clk);
            wait_n++;
        end
        chk("clr_busy_seen", {31'd0, out_clr_busy}, 32'd1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge axis_clk); #1;
                in_clr_start = (k == 4);
                @(negedge axis_clk);
            end
            chk($sformatf("clr%0d_busy", k), {31'd0, out_clr_busy}, 32'd1);
            chk($sformatf("clr%0d_en", k), {31'd0, out_ram_EN}, 32'd1);
            chk($sformatf("clr%0d_we", k), {28'd0, out_ram_WE}, 32'hF);
            chk($sformatf("clr%0d_addr", k), {22'd0, out_ram_A}, k);
            chk($sformatf("clr%0d_di", k), out_ram_Di, 32'd0);
            chk($sformatf("clr%0d_done", k), {31'd0, out_clr_done}, 32'd0);
            shadow[k] = 32'd0;
        end
        @(posedge axis_clk); #1;
        in_clr_start = 1'b0;
        @(negedge axis_clk);
        chk("clr_done_pulse", {31'd0, out_clr_done}, 32'd1);
        chk("clr_busy_end", {31'd0, out_clr_busy}, 32'd0);
        @(posedge axis_clk); #1;
        @(negedge axis_clk);
        chk("clr_done_once", {31'd0, out_clr_done}, 32'd0);
        @(posedge axis_clk); #1;
        set_in(1'b1, 3'b010, 3'b000, 10'd2, 32'h0);
        step("post_clr_read", 3'b010, 1'b1);
        set_in(1'b1, 3'b000, 3'b000, 10'd0, 32'h0);
        repeat (3) step("idle_ready", 3'b000, 1'b1);

        // Stall statistic across an 8-cycle clear with requester 1 waiting
        in_clr_start = 1'b1;
        step("stats_clr_start", 3'b000, 1'b1);
        in_clr_start = 1'b0;
        set_in(1'b1, 3'b010, 3'b000, 10'd2, 32'h0);
        @(negedge axis_clk);
        stall0 = out_stall_cnt;
        chk("stats_clr_ready0", {29'd0, out_req_ready}, 32'd0);
        for (int k = 1; k < 8; k++) begin
            @(posedge axis_clk); #1; @(negedge axis_clk);
            chk($sformatf("stats_clr_ready%0d", k), {29'd0, out_req_ready}, 32'd0);
        end
        @(posedge axis_clk); #1;
        set_in(1'b1, 3'b000, 3'b000, 10'd0, 32'h0);
        @(negedge axis_clk);
`ifdef BRAM_ARB_STATS_EN
        chk("stall_delta", {16'd0, out_stall_cnt - stall0}, 32'd8);
`else
        chk("stall_delta", {16'd0, out_stall_cnt - stall0}, 32'd0);
        chk("stall_tied", {16'd0, out_stall_cnt}, 32'd0);
`endif
        @(posedge axis_clk); #1;
        repeat (4) step("stats_idle", 3'b000, 1'b1);

        // Reset at the 4th clear cycle aborts the clear
        in_clr_start = 1'b1;
        step("abort_clr_start", 3'b000, 1'b1);
        in_clr_start = 1'b0;
        wait_n = 0;
        @(negedge axis_clk);
        while (!out_clr_busy && (wait_n < 4)) begin
            @(posedge axis_clk); #1; @(negedge axis_clk);
            wait_n++;
        end
        chk("abort_busy_seen", {31'd0, out_clr_busy}, 32'd1);
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst = 1'b1;
        sb.delete();
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge axis_clk);
            chk("abort_no_done", {31'd0, out_clr_done}, 32'd0);
            chk("abort_not_busy", {31'd0, out_clr_busy}, 32'd0);
            @(posedge axis_clk); #1;
        end
        set_in(1'b1, 3'b010, 3'b010, 10'd60, 32'h5555_0000);
        step("abort_back_in_arb", 3'b010, 1'b1);

        // Reset with a read in flight drops its response
        set_in(1'b1, 3'b100, 3'b000, 10'd3, 32'h0);
        step("inflight_read", 3'b100, 1'b0);
        set_in(1'b1, 3'b000, 3'b000, 10'd0, 32'h0);
        axis_rst = 1'b1;
        @(posedge axis_clk); #1;
        axis_rst = 1'b0;
        @(negedge axis_clk);
        chk("inflight_dropped", {29'd0, out_rsp_valid}, 32'd0);
        chk("inflight_data", out_rsp_data, 32'd0);
        @(posedge axis_clk); #1;

        repeat (4) step("drain_idle", 3'b000, 1'b1);
        chk("scoreboard_drain", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Registered, parametrised successor to the FIR's combinational BRAM access steering.
- Arbitrates NUM_REQ requesters onto one single-port BRAM:
  - index 0 = core, fixed top priority;
  - indices 1..NUM_REQ-1 = round-robin (axistream, axilite, ...).
- Adds read-response routing with fixed latency and a hardware clear sequencer that zero-fills the RAM.
- Sits between the FIR core / AXI interface blocks and the tap or data BRAM.

Parameters:
pDATA_WIDTH, 32, data width; must be a multiple of 8.
pADDR_WIDTH, 10, BRAM address width.
NUM_REQ, 3, requester count, minimum 2.
pDEPTH, 1024, words zeroed by a clear; must be ≤ 2**pADDR_WIDTH.
RD_LAT, 1, BRAM read latency in cycles (1 or 2).
LITE_IDX, 2, requester gated by in_ap_idle (axilite).

Ports:
axis_clk  in  1  clock
axis_rst  in  1  synchronous active-high reset
in_ap_idle  in  1  1 = core idle; requester LITE_IDX is eligible only when 1
in_req_valid  in  NUM_REQ  per-requester request
in_req_we  in  NUM_REQ  1 = write, 0 = read
in_req_addr  in  NUM_REQ*pADDR_WIDTH  packed addresses, requester i at [i*AW +: AW]
in_req_wdata  in  NUM_REQ*pDATA_WIDTH  packed write data
out_req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid&&ready
out_rsp_valid  out  NUM_REQ  one-hot read-data pulse to the originating requester
out_rsp_data  out  pDATA_WIDTH  read data, qualified by out_rsp_valid
in_clr_start  in  1  pulse: begin zero-fill
out_clr_busy  out  1  clear in progress
out_clr_done  out  1  one-cycle pulse after the last clear write
out_ram_EN  out  1  BRAM enable
out_ram_WE  out  pDATA_WIDTH/8  BRAM byte write enables, all-set on writes
out_ram_A  out  pADDR_WIDTH  BRAM address
out_ram_Di  out  pDATA_WIDTH  BRAM write data
in_ram_Do  in  pDATA_WIDTH  BRAM read data
out_stall_cnt  out  16  stall statistic; see Optional Feature

Behaviour:
Reset:
- All outputs 0; state ARB; rr_ptr = 1; clear counter 0; response pipe empty.

State ARB:
- out_req_ready is combinational from valid, state, rr_ptr and in_ap_idle.
- If in_req_valid[0], grant 0.
- Otherwise grant the first eligible valid requester searching rr_ptr, rr_ptr+1, ... with wrap over 1..NUM_REQ-1.
- Requester LITE_IDX is ineligible while in_ap_idle = 0.
- At most one ready bit is set.
- After a grant to i ≥ 1, rr_ptr = i+1, wrapping to 1. A grant to 0 leaves rr_ptr unchanged.

BRAM drive:
- An accepted request in cycle t drives out_ram_EN/WE/A/Di registered in cycle t+1.
- With no acceptance in cycle t, EN = 0 and WE = 0 in cycle t+1.

Read response:
- Accepted read → out_rsp_valid[i] = 1 with out_rsp_data = in_ram_Do in cycle t+1+RD_LAT.
- Tracked by an (RD_LAT+1)-deep pipe of {valid, id}.
- Back-to-back reads give back-to-back responses. Writes produce no response.

in_clr_start:
- In ARB with in_clr_start = 1: go to CLR. No grant is issued that cycle, even if valid requests exist.

State CLR:
- out_req_ready = 0 and out_clr_busy = 1.
- Each cycle drives EN = 1, WE = all-ones, Di = 0, A = counter, counter+1.
- After the write to address pDEPTH-1: out_clr_done = 1 for 1 cycle, busy = 0, counter = 0, return to ARB.
- A clear takes exactly pDEPTH write cycles.
- in_clr_start during CLR is ignored.
- Reads accepted before CLR entry still return their responses.

Reset mid-operation:
- axis_rst during CLR or with reads in flight: abort, no clr_done, no responses delivered.

Optional Feature:
BRAM_ARB_STATS_EN
- Defined: out_stall_cnt is a 16-bit saturating counter.
  - Increments each cycle in which any in_req_valid is 1 without a matching ready. CLR cycles count.
  - Holds at 16'hFFFF; cleared only by axis_rst.
- Undefined: out_stall_cnt is tied to 0 and no counter logic exists.

Test Plan:
- Core priority: valid = 3'b111, ap_idle = 1 for 3 cycles → ready = 001 each cycle, rr_ptr stays 1.
- Round robin: valid = 3'b110, ap_idle = 1 → ready sequence 010, 100, 010, 100.
- Lite gating: ap_idle = 0, valid = 3'b100 → ready = 000. ap_idle→1 → ready = 100 the same cycle.
- Read latency, RD_LAT = 1: write addr 5 data 32'hDEADBEEF by req 1, then read addr 5 by req 2 accepted at cycle t → rsp_valid = 100 with data DEADBEEF at t+2.
- Clear, pDEPTH = 8: clr_start pulse.
  - busy for 8 cycles with WE = 4'hF, Di = 0 at A = 0..7, then clr_done for 1 cycle.
  - Subsequent read of addr 3 returns 0.
  - Repeat with axis_rst at the 4th clear cycle → no clr_done, state ARB.
- Stats, macro defined: hold valid = 3'b010 during an 8-cycle clear → out_stall_cnt = 8. Macro undefined → 0.
